// File: rtl/alu_fsm_pipe.sv
// ---------------------------------------------------------------------------
// alu_fsm_pipe
//
// Queued multi-cycle ALU. Commands arrive over a valid/ready handshake and
// wait in a small FIFO. An FSM pops them one at a time:
// - single-cycle ops finish in EXEC;
// - divide runs as a restoring divider, one quotient bit per cycle.
// Results leave over a valid/ready handshake. Each result carries an error
// flag for divide-by-zero or an illegal op code.
//
// Parameters:
//   W      operand width (>= 4); results are 2*W wide
//   DEPTH  command FIFO depth (power of 2, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   command present on A/B/op_sel
//   in_ready   FIFO has room (registered)
//   A, B       W-bit operands
//   op_sel     4-bit operation code
//   out_valid  result present
//   out_ready  consumer takes the result
//   result     2*W-bit result ({remainder, quotient} for divides)
//   err        divide-by-zero or illegal op for this result
//   busy       FSM not idle or FIFO not empty
//
// Build option:
//   SIGNED_OPS_EN
//   - When defined, op 1101 is a signed multiply and op 1110 is a signed
//     divide. Signed divide takes one extra fix-up cycle.
//   - When undefined, both codes are illegal.
// ---------------------------------------------------------------------------
module alu_fsm_pipe #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [3:0]     op_sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           err,
    output logic           busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_DIV,
        S_FIX,
        S_HOLD
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [W-1:0] r_fifoA  [DEPTH];
    logic [W-1:0] r_fifoB  [DEPTH];
    logic [3:0]   r_fifoOp [DEPTH];
    logic [PW:0]  r_wrPtr;
    logic [PW:0]  r_rdPtr;
    logic         r_inReady;

    logic         w_push;
    logic         w_pop;
    logic         w_empty;
    logic [PW:0]  w_count;
    logic [PW:0]  w_countNext;

    assign w_empty     = (r_wrPtr == r_rdPtr);
    assign w_push      = in_valid && r_inReady;
    assign w_count     = r_wrPtr - r_rdPtr;
    assign w_countNext = w_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

    // in_ready is computed from the occupancy after this cycle's push/pop.
    // A full FIFO therefore refuses a push even while it pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_inReady <= 1'b1;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + (PW+1)'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + (PW+1)'(1);
            r_inReady <= (w_countNext != (PW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoA[r_wrPtr[PW-1:0]]  <= A;
            r_fifoB[r_wrPtr[PW-1:0]]  <= B;
            r_fifoOp[r_wrPtr[PW-1:0]] <= op_sel;
        end
    end

    // ----------------------------------------------------------- FSM state
    state_t         r_state;
    state_t         w_nextState;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [3:0]     r_op;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_quot;
    logic [W-1:0]   r_div;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_result;
    logic           r_err;
    logic           r_outValid;
`ifdef SIGNED_OPS_EN
    logic           r_negQ;
    logic           r_negR;
`endif

    logic           w_handshake;
    logic           w_isDiv;
    logic           w_isSignedDiv;
    logic [W-1:0]   w_divA;
    logic [W-1:0]   w_divB;

    assign w_handshake = r_outValid && out_ready;
    assign in_ready    = r_inReady;
    assign out_valid   = r_outValid;
    assign result      = r_result;
    assign err         = r_err;
    assign busy        = (r_state != S_IDLE) || !w_empty;

    // Decode which latched ops use the iterative divider. For a signed
    // divide, the divider works on operand magnitudes. The signs are
    // reapplied in the fix-up state.
    always_comb begin
        w_isDiv       = (r_op == 4'b0011);
        w_isSignedDiv = 1'b0;
        w_divA        = r_a;
        w_divB        = r_b;
`ifdef SIGNED_OPS_EN
        if (r_op == 4'b1110) begin
            w_isDiv       = 1'b1;
            w_isSignedDiv = 1'b1;
            w_divA        = r_a[W-1] ? -r_a : r_a;
            w_divB        = r_b[W-1] ? -r_b : r_b;
        end
`endif
    end

    // --------------------------------------------------------- single-cycle ALU
    logic [2*W-1:0]        w_aExt;
    logic [2*W-1:0]        w_bExt;
    logic signed [2*W-1:0] w_aSext;
    logic [SW-1:0]         w_shAmt;
    logic [2*W-1:0]        w_aluResult;
    logic                  w_aluErr;
`ifdef SIGNED_OPS_EN
    logic signed [2*W-1:0] w_bSext;
    assign w_bSext = {{W{r_b[W-1]}}, r_b};
`endif

    assign w_aExt  = {{W{1'b0}}, r_a};
    assign w_bExt  = {{W{1'b0}}, r_b};
    assign w_aSext = {{W{r_a[W-1]}}, r_a};
    assign w_shAmt = r_b[SW-1:0];

    // Divide codes only reach this path with a zero divisor, so they
    // report divide-by-zero here.
    always_comb begin
        w_aluResult = '0;
        w_aluErr    = 1'b0;
        case (r_op)
            4'b0000: w_aluResult = w_aExt + w_bExt;
            4'b0001: w_aluResult = w_aExt - w_bExt;
            4'b0010: w_aluResult = w_aExt * w_bExt;
            4'b0011: begin
                w_aluResult = '1;
                w_aluErr    = 1'b1;
            end
            4'b0100: w_aluResult = w_aExt & w_bExt;
            4'b0101: w_aluResult = w_aExt | w_bExt;
            4'b0110: w_aluResult = w_aExt ^ w_bExt;
            4'b0111: w_aluResult = {{W{1'b0}}, ~r_a};
            4'b1000: w_aluResult = w_aExt << w_shAmt;
            4'b1001: w_aluResult = w_aExt >> w_shAmt;
            4'b1010: w_aluResult = $unsigned(w_aSext >>> w_shAmt);
            4'b1011: w_aluResult = (r_a < r_b) ? w_aExt : w_bExt;
            4'b1100: w_aluResult = (r_a > r_b) ? w_aExt : w_bExt;
`ifdef SIGNED_OPS_EN
            4'b1101: w_aluResult = $unsigned(w_aSext * w_bSext);
            4'b1110: begin
                w_aluResult = '1;
                w_aluErr    = 1'b1;
            end
`endif
            default: begin
                w_aluResult = '0;
                w_aluErr    = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------- divider step
    logic [W:0]   w_shifted;
    logic [W:0]   w_diff;
    logic         w_qBit;
    logic [W-1:0] w_remNext;
    logic [W-1:0] w_quotNext;

    // Restoring step. Shift the next dividend bit into the partial
    // remainder and trial-subtract the divisor. A borrow in bit W means the
    // subtraction is undone.
    assign w_shifted  = {r_rem, r_quot[W-1]};
    assign w_diff     = w_shifted - {1'b0, r_div};
    assign w_qBit     = !w_diff[W];
    assign w_remNext  = w_qBit ? w_diff[W-1:0] : w_shifted[W-1:0];
    assign w_quotNext = {r_quot[W-2:0], w_qBit};

`ifdef SIGNED_OPS_EN
    logic [W-1:0] w_fixRem;
    logic [W-1:0] w_fixQuot;
    assign w_fixRem  = r_negR ? -r_rem  : r_rem;
    assign w_fixQuot = r_negQ ? -r_quot : r_quot;
`endif

    // ----------------------------------------------------- next state / pop
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_isDiv && (r_b != '0)) w_nextState = S_DIV;
                else                        w_nextState = S_HOLD;
            end
            S_DIV: begin
                if (r_cnt == CW'(W-1))
                    w_nextState = w_isSignedDiv ? S_FIX : S_HOLD;
            end
            S_FIX:  w_nextState = S_HOLD;
            S_HOLD: begin
                if (w_handshake) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    // Datapath registers.
    // - result/err only change on the way into HOLD, so they are stable
    //   for as long as the consumer stalls.
    // - out_valid lags entry into HOLD by one cycle, so a result is offered
    //   two cycles after its pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
            r_outValid <= 1'b0;
`ifdef SIGNED_OPS_EN
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
`endif
        end else begin
            r_outValid <= (r_state == S_HOLD) && !w_handshake;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_a  <= r_fifoA[r_rdPtr[PW-1:0]];
                        r_b  <= r_fifoB[r_rdPtr[PW-1:0]];
                        r_op <= r_fifoOp[r_rdPtr[PW-1:0]];
                    end
                end
                S_EXEC: begin
                    if (w_nextState == S_DIV) begin
                        r_rem  <= '0;
                        r_quot <= w_divA;
                        r_div  <= w_divB;
                        r_cnt  <= '0;
`ifdef SIGNED_OPS_EN
                        r_negQ <= w_isSignedDiv && (r_a[W-1] ^ r_b[W-1]);
                        r_negR <= w_isSignedDiv && r_a[W-1];
`endif
                    end else begin
                        r_result <= w_aluResult;
                        r_err    <= w_aluErr;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_remNext;
                    r_quot <= w_quotNext;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_nextState == S_HOLD) begin
                        r_result <= {w_remNext, w_quotNext};
                        r_err    <= 1'b0;
                    end
                end
                S_FIX: begin
`ifdef SIGNED_OPS_EN
                    r_result <= {w_fixRem, w_fixQuot};
                    r_err    <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_fsm_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_fsm_pipe
//
// Directed testbench for alu_fsm_pipe (W=16, DEPTH=4).
//
// Latency convention: latency is counted in falling edges after the rising
// edge that accepts a command.
// - That edge is one cycle before the pop, so a single-cycle op shows
//   out_valid at 3.
// - An unsigned divide shows it at 19 (W + 3).
// ---------------------------------------------------------------------------
module tb_alu_fsm_pipe;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [3:0]     op_sel;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           err;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;

    alu_fsm_pipe #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op_sel    (op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count every comparison and report a mismatch in one line.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one command at a falling edge and hold it until the FIFO takes
    // it. The task returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        op_sel   = op;
        A        = a;
        B        = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptReady", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One command through an idle pipe: check latency, then {err,result},
    // then that out_valid drops after the handshake.
    task automatic runSingle(input string tag, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] expRes, input logic expErr,
                             input int expLat);
        int cycles;
        applyStimulus(op, a, b);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, ".lat"}, 64'(cycles), 64'(expLat));
        checkOutput({tag, ".res"}, 64'({err, result}), 64'({expErr, expRes}));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, ".drop"}, 64'(out_valid), 64'd0);
    endtask

    logic [2*W-1:0] expQ [5];
    logic [2*W-1:0] prevResult;
    logic           stallPrev;
    int             idx;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        op_sel    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst.outValid", 64'(out_valid), 64'd0);
        checkOutput("rst.result",   64'(result),    64'd0);
        checkOutput("rst.err",      64'(err),       64'd0);
        checkOutput("rst.busy",     64'(busy),      64'd0);
        checkOutput("rst.inReady",  64'(in_ready),  64'd1);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single-command vectors");
        runSingle("addCarry", 4'b0000, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 3);
        runSingle("subNeg",   4'b0001, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 1'b0, 3);
        runSingle("mulMax",   4'b0010, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 3);
        runSingle("and",      4'b0100, 16'hF0F0, 16'hFF00, 32'h0000_F000, 1'b0, 3);
        runSingle("or",       4'b0101, 16'hF0F0, 16'hFF00, 32'h0000_FFF0, 1'b0, 3);
        runSingle("xor",      4'b0110, 16'hF0F0, 16'hFF00, 32'h0000_0FF0, 1'b0, 3);
        runSingle("notA",     4'b0111, 16'hF0F0, 16'hFF00, 32'h0000_0F0F, 1'b0, 3);
        runSingle("shl",      4'b1000, 16'h8001, 16'h0004, 32'h0008_0010, 1'b0, 3);
        runSingle("shlMask",  4'b1000, 16'h0001, 16'h0013, 32'h0000_0008, 1'b0, 3);
        runSingle("lsr",      4'b1001, 16'h8000, 16'h0004, 32'h0000_0800, 1'b0, 3);
        runSingle("asr",      4'b1010, 16'h8000, 16'h0004, 32'hFFFF_F800, 1'b0, 3);
        runSingle("minU",     4'b1011, 16'h1234, 16'h0100, 32'h0000_0100, 1'b0, 3);
        runSingle("maxU",     4'b1100, 16'h1234, 16'h0100, 32'h0000_1234, 1'b0, 3);
        runSingle("div100_7", 4'b0011, 16'd100,  16'd7,    32'h0002_000E, 1'b0, 19);
        runSingle("divBig",   4'b0011, 16'hFFFF, 16'h0010, 32'h000F_0FFF, 1'b0, 19);
        runSingle("divZero",  4'b0011, 16'd100,  16'd0,    32'hFFFF_FFFF, 1'b1, 3);
        runSingle("illegalF", 4'b1111, 16'h1234, 16'h5678, 32'h0000_0000, 1'b1, 3);
`ifdef SIGNED_OPS_EN
        runSingle("smul",     4'b1101, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 1'b0, 3);
        runSingle("sdiv",     4'b1110, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1'b0, 20);
        runSingle("sdivZero", 4'b1110, 16'hFFF9, 16'h0000, 32'hFFFF_FFFF, 1'b1, 3);
`else
        runSingle("illegalD", 4'b1101, 16'hFFFE, 16'h0003, 32'h0000_0000, 1'b1, 3);
        runSingle("illegalE", 4'b1110, 16'hFFF9, 16'h0002, 32'h0000_0000, 1'b1, 3);
`endif

        $display("[TB] fill FIFO while stalled, then drain with random out_ready");
        expQ[0] = 32'h0000_0101;
        expQ[1] = 32'h000A_001E;
        expQ[2] = 32'h0001_0000;
        expQ[3] = 32'h0000_0FF0;
        expQ[4] = 32'hFFFF_FFF0;
        applyStimulus(4'b0000, 16'h0001, 16'h0100);
        applyStimulus(4'b0011, 16'd1000, 16'd33);
        applyStimulus(4'b0010, 16'h0100, 16'h0100);
        applyStimulus(4'b0110, 16'h00FF, 16'h0F0F);
        applyStimulus(4'b0001, 16'h0010, 16'h0020);
        checkOutput("fill.inReadyLow", 64'(in_ready), 64'd0);
        checkOutput("fill.busy",       64'(busy),     64'd1);
        repeat (5) @(negedge clk);
        checkOutput("fill.stillFull",  64'(in_ready), 64'd0);

        idx       = 0;
        stallPrev = 1'b0;
        for (int c = 0; c < 600 && idx < 5; c++) begin
            if (stallPrev)
                checkOutput("holdStable", 64'(result), 64'(prevResult));
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                checkOutput($sformatf("order%0d", idx), 64'({err, result}),
                            64'({1'b0, expQ[idx]}));
                idx++;
            end
            stallPrev  = out_valid && !out_ready;
            prevResult = result;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput("drainCount",     64'(idx),       64'd5);
        @(negedge clk);
        checkOutput("drain.outValid", 64'(out_valid), 64'd0);
        checkOutput("drain.busy",     64'(busy),      64'd0);
        checkOutput("drain.inReady",  64'(in_ready),  64'd1);

        $display("[TB] reset during divide");
        applyStimulus(4'b0011, 16'hFFFF, 16'h0003);
        applyStimulus(4'b0000, 16'h0001, 16'h0001);
        repeat (4) @(negedge clk);
        checkOutput("midDiv.busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("midRst.outValid", 64'(out_valid), 64'd0);
        checkOutput("midRst.result",   64'(result),    64'd0);
        checkOutput("midRst.err",      64'(err),       64'd0);
        checkOutput("midRst.busy",     64'(busy),      64'd0);
        checkOutput("midRst.inReady",  64'(in_ready),  64'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("postRst.noResult", 64'(out_valid), 64'd0);
        checkOutput("postRst.idle",     64'(busy),      64'd0);
        runSingle("postRstAdd", 4'b0000, 16'd2, 16'd3, 32'h0000_0005, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
